// File: rtl/imem_loader.sv
// imem_loader: boot loader that writes a checksummed UART frame into instruction memory and then releases the core
module imem_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          ADDR_W      = $clog2(DEPTH_WORDS),
    parameter int          TIMEOUT_CYC = 50000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              start_req,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, RUN, ERR} state_e;

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic [TW-1:0]     idle_q, idle_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;
    logic              core_rst_n_q, busy_q, load_done_q, load_err_q;
    logic              in_frame, timeout;

    // Next-state decode: bytes are shifted in from the top so the first byte ends in [7:0]
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        csum_d     = csum_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        in_frame   = state_q inside {LEN0, LEN1, DATA, CSUM};
        timeout    = in_frame && !rx_valid && idle_q == TW'(TIMEOUT_CYC - 1);
        idle_d     = (!in_frame || rx_valid || timeout) ? '0 : idle_q + TW'(1);
        case (state_q)
            IDLE, ERR: if (rx_valid && rx_data == SYNC_BYTE) state_d = LEN0;
            LEN0: if (rx_valid) begin
                len_d   = {8'h00, rx_data};
                state_d = LEN1;
            end
            LEN1: if (rx_valid) begin
                len_d      = {rx_data, len_q[7:0]};
                word_cnt_d = '0;
                byte_idx_d = '0;
                csum_d     = '0;
                state_d    = (len_d == 16'd0 || len_d > 16'(DEPTH_WORDS)) ? ERR : DATA;
            end
            DATA: if (rx_valid) begin
                word_d     = {rx_data, word_q[31:8]};
                csum_d     = csum_q ^ rx_data;
                byte_idx_d = byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                    im_we_d    = 1'b1;
                    im_addr_d  = word_cnt_q;
                    im_wdata_d = word_d;
                    word_cnt_d = word_cnt_q + ADDR_W'(1);
                    state_d    = (16'(word_cnt_q) == len_q - 16'd1) ? CSUM : DATA;
                end
            end
            CSUM: if (rx_valid) state_d = (rx_data == csum_q) ? RUN : ERR;
            RUN:  if (start_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (timeout) state_d = ERR;
    end

    // State and registered outputs; status flags follow the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            csum_q       <= '0;
            idle_q       <= '0;
            im_we_q      <= 1'b0;
            im_addr_q    <= '0;
            im_wdata_q   <= '0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            csum_q       <= csum_d;
            idle_q       <= idle_d;
            im_we_q      <= im_we_d;
            im_addr_q    <= im_addr_d;
            im_wdata_q   <= im_wdata_d;
            core_rst_n_q <= state_d == RUN;
            busy_q       <= state_d inside {LEN0, LEN1, DATA, CSUM};
            load_done_q  <= state_d == RUN;
            load_err_q   <= state_d == ERR;
        end
    end

    assign im_we      = im_we_q;
    assign im_addr    = im_addr_q;
    assign im_wdata   = im_wdata_q;
    assign core_rst_n = core_rst_n_q;
    assign busy       = busy_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random and directed frames checked against a frame-level model of the loader
module tb_imem_loader;
    localparam int T = 300;

    logic       clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, start_req = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       im_we, core_rst_n, busy, load_done, load_err;
    logic [7:0] im_addr;
    logic [31:0] im_wdata;

    int n_checks = 0, n_errors = 0;
    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  pl[$];

    always #5 clk = ~clk;

    imem_loader #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .start_req(start_req), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .core_rst_n(core_rst_n), .busy(busy), .load_done(load_done), .load_err(load_err)
    );

    // capture every memory write pulse
    always @(negedge clk) if (rst_n && im_we) begin
        wa_q.push_back(im_addr);
        wd_q.push_back(im_wdata);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic status(input string tag, input logic b, input logic d, input logic e);
        check({tag, " busy"}, busy, b);
        check({tag, " load_done"}, load_done, d);
        check({tag, " load_err"}, load_err, e);
        check({tag, " core_rst_n"}, core_rst_n, d);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) begin @(posedge clk); #1; end
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start_req = 1'b1;
        @(posedge clk); #1;
        start_req = 1'b0;
        status("start_req", 1'b0, 1'b0, 1'b0);
    endtask

    // send junk, header, payload from pl and checksum (xored with bad); compare against the frame model
    task automatic run_frame(input int n, input logic [7:0] bad, input int maxgap);
        logic [7:0] cs, j;
        wa_q.delete();
        wd_q.delete();
        repeat ($urandom_range(0, 3)) begin
            j = 8'($urandom);
            if (j == 8'hA5) j = 8'h00;
            send(j, $urandom_range(0, maxgap));
        end
        send(8'hA5, 0);
        send(8'(n), $urandom_range(0, maxgap));
        send(8'(n >> 8), $urandom_range(0, maxgap));
        if (n == 0 || n > 256) begin
            status("bad_len", 1'b0, 1'b0, 1'b1);
            check("bad_len writes", wa_q.size(), 0);
            return;
        end
        cs = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            cs ^= pl[i];
            send(pl[i], $urandom_range(0, maxgap));
        end
        send(cs ^ bad, $urandom_range(0, maxgap));
        check("write count", wa_q.size(), n);
        for (int i = 0; i < n && i < wa_q.size(); i++) begin
            check("write addr", wa_q[i], 8'(i));
            check("write data", wd_q[i], {pl[4*i+3], pl[4*i+2], pl[4*i+1], pl[4*i]});
        end
        status(bad != 0 ? "csum_bad" : "csum_ok", 1'b0, bad == 0, bad != 0);
    endtask

    task automatic rand_pl(input int n);
        pl.delete();
        repeat (4 * n) pl.push_back(8'($urandom));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        status("reset", 1'b0, 1'b0, 1'b0);
        check("reset im_we", im_we, 0);
        check("reset im_addr", im_addr, 0);
        check("reset im_wdata", im_wdata, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        pl = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_frame(2, 8'h00, 0);
        pulse_start();
        run_frame(2, 8'h01, 2);
        run_frame(2, 8'h00, 1);
        repeat (3) send(8'hA5, 1);
        status("run ignores rx", 1'b0, 1'b1, 1'b0);
        pulse_start();

        run_frame(0, 8'h00, 1);
        run_frame(257, 8'h00, 1);

        wa_q.delete();
        send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0); send(8'h13, 0); send(8'h00, 0);
        repeat (T - 1) @(posedge clk);
        #1;
        status("idle T-1", 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        status("timeout", 1'b0, 1'b0, 1'b1);
        check("timeout writes", wa_q.size(), 0);

        send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0); send(8'h13, 0); send(8'h00, 0);
        send(8'h00, T - 1);
        status("byte wins", 1'b1, 1'b0, 1'b0);
        send(8'h00, 0);
        send(8'h13, T - 1);
        status("late csum", 1'b0, 1'b1, 1'b0);
        check("late write", wd_q.size() == 1 ? wd_q[0] : 32'hx, 32'h00000013);

        for (int it = 0; it < 25; it++) begin
            int n, r;
            if (load_done) pulse_start();
            r = $urandom_range(0, 9);
            n = r == 0 ? 0 : r == 1 ? $urandom_range(257, 600) : $urandom_range(1, 8);
            rand_pl(n > 256 ? 0 : n);
            run_frame(n, $urandom_range(0, 1) ? 8'h00 : 8'(1 << $urandom_range(0, 7)), 3);
        end

        if (load_done) pulse_start();
        rand_pl(3);
        send(8'hA5, 0); send(8'h02, 0); send(8'h00, 0);
        for (int i = 0; i < 4; i++) send(pl[i], 0);
        check("pre-reset im_we", im_we, 1);
        rst_n = 1'b0;
        #1;
        status("async reset", 1'b0, 1'b0, 1'b0);
        check("async reset im_we", im_we, 0);
        check("async reset im_addr", im_addr, 0);
        check("async reset im_wdata", im_wdata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(3, 8'h00, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
